// File: rtl/dmem_ram_stream_if.sv
// CPU data-memory bus plus dump stream port for dmem_ram_stream.
// The master side drives requests and the stream sink's ready; the slave side is the memory.
interface dmem_ram_stream_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W-1:0]     rd;
    logic                  oob_err;
    logic                  dump_start;
    logic                  dump_busy;
    logic                  dump_valid;
    logic                  dump_ready;
    logic [DATA_W-1:0]     dump_data;
    logic [ADDR_W-1:0]     dump_addr;
    logic                  dump_done;

    modport master (
        output we, be, address, wd, dump_start, dump_ready,
        input  rd, oob_err, dump_busy, dump_valid, dump_data, dump_addr, dump_done
    );

    modport slave (
        input  we, be, address, wd, dump_start, dump_ready,
        output rd, oob_err, dump_busy, dump_valid, dump_data, dump_addr, dump_done
    );
endinterface

// File: rtl/dmem_ram_stream.sv
// Byte-enable data memory with a registered CPU port (A) and a read-only dump engine (B)
// that streams every word out over a valid/ready port through an output + skid register.
module dmem_ram_stream #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 129600,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    dmem_ram_stream_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              oob_q, oob_d;
    logic              f_vld_q, f_vld_d;
    logic [DATA_W-1:0] f_data_q, f_data_d;
    logic [ADDR_W-1:0] f_addr_q, f_addr_d;
    logic              o_vld_q, o_vld_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;
    logic [ADDR_W-1:0] o_addr_q, o_addr_d;
    logic              s_vld_q, s_vld_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic              done_q, done_d;

    logic              a_in_range;
    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  p_idx;
    logic [DATA_W-1:0] wr_word;
    logic              pop;
    logic              issue;
    logic [1:0]        occ;

    assign a_in_range = (bus.address < ADDR_W'(DEPTH));
    assign a_idx      = bus.address[IDX_W-1:0];
    assign p_idx      = ptr_q[IDX_W-1:0];

    always_comb begin
        wr_word = mem[a_idx];
        for (int i = 0; i < BE_W; i++) begin
            if (bus.be[i]) wr_word[8*i +: 8] = bus.wd[8*i +: 8];
        end
    end

    // Both ports read the pre-edge contents, so reads are read-first w.r.t. this write.
    always_ff @(posedge clk) begin
        if (bus.we && a_in_range) mem[a_idx] <= wr_word;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        done_d   = 1'b0;
        o_vld_d  = o_vld_q;
        o_data_d = o_data_q;
        o_addr_d = o_addr_q;
        s_vld_d  = s_vld_q;
        s_data_d = s_data_q;
        s_addr_d = s_addr_q;

        rd_d  = a_in_range ? mem[a_idx] : '0;
        oob_d = oob_q | ~a_in_range;

        // Credit check: a fetch is launched only if its word is guaranteed a slot
        // in output/skid, counting the word already in flight.
        pop   = o_vld_q & bus.dump_ready;
        occ   = 2'(o_vld_q) + 2'(s_vld_q) + 2'(f_vld_q);
        issue = (state_q == RUN) && ((occ - 2'(pop)) < 2'd2);

        f_vld_d  = issue;
        f_data_d = mem[p_idx];
        f_addr_d = ptr_q;

        if (pop || !o_vld_q) begin
            if (s_vld_q) begin
                o_vld_d  = 1'b1;
                o_data_d = s_data_q;
                o_addr_d = s_addr_q;
                s_vld_d  = f_vld_q;
                s_data_d = f_data_q;
                s_addr_d = f_addr_q;
            end else begin
                o_vld_d = f_vld_q;
                if (f_vld_q) begin
                    o_data_d = f_data_q;
                    o_addr_d = f_addr_q;
                end
            end
        end else if (f_vld_q) begin
            s_vld_d  = 1'b1;
            s_data_d = f_data_q;
            s_addr_d = f_addr_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.dump_start) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (o_addr_q == ADDR_W'(DEPTH - 1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rd_q     <= '0;
            oob_q    <= 1'b0;
            f_vld_q  <= 1'b0;
            f_data_q <= '0;
            f_addr_q <= '0;
            o_vld_q  <= 1'b0;
            o_data_q <= '0;
            o_addr_q <= '0;
            s_vld_q  <= 1'b0;
            s_data_q <= '0;
            s_addr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rd_q     <= rd_d;
            oob_q    <= oob_d;
            f_vld_q  <= f_vld_d;
            f_data_q <= f_data_d;
            f_addr_q <= f_addr_d;
            o_vld_q  <= o_vld_d;
            o_data_q <= o_data_d;
            o_addr_q <= o_addr_d;
            s_vld_q  <= s_vld_d;
            s_data_q <= s_data_d;
            s_addr_q <= s_addr_d;
            done_q   <= done_d;
        end
    end

    assign bus.rd         = rd_q;
    assign bus.oob_err    = oob_q;
    assign bus.dump_busy  = (state_q != IDLE);
    assign bus.dump_valid = o_vld_q;
    assign bus.dump_data  = o_data_q;
    assign bus.dump_addr  = o_addr_q;
    assign bus.dump_done  = done_q;
endmodule

// File: tb/tb_dmem_ram_stream.sv
// Scoreboard bench for dmem_ram_stream (DEPTH=16): stimulus queues expected CPU reads and
// dump beats, an independent monitor pops and compares them as the DUT presents outputs.
module tb_dmem_ram_stream;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_ram_stream_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_ram_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    int          ready_mode = 0;
    int          done_cnt = 0;
    int          first_cyc = 0;
    int          last_cyc  = 0;
    beat_t       beat_q[$];
    logic [31:0] rd_exp_q[$];
    logic        rd_tag   = 1'b0;
    logic        rd_tag_d = 1'b0;
    logic [31:0] mem_m [DEPTH];

    bit          stalled   = 1'b0;
    bit          last_xfer = 1'b0;
    beat_t       held;
    beat_t       exp_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_tag_d <= rd_tag;
    end

    initial begin
        bus.dump_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.dump_ready = 1'b1;
                2:       bus.dump_ready = ($urandom_range(0, 1) == 1);
                default: bus.dump_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples on the falling edge, between active edges.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled   = 1'b0;
                last_xfer = 1'b0;
            end else begin
                if (rd_tag_d) begin
                    if (rd_exp_q.size() == 0) fail("rd_unexpected");
                    else check("rd", bus.rd, rd_exp_q.pop_front());
                end
                if (last_xfer) begin
                    check("done_pulse", bus.dump_done, 1);
                    check("busy_after_done", bus.dump_busy, 0);
                    last_xfer = 1'b0;
                end
                if (bus.dump_done) done_cnt++;
                if (stalled) begin
                    check("stall_valid", bus.dump_valid, 1);
                    check("stall_data", bus.dump_data, held.data);
                    check("stall_addr", bus.dump_addr, held.addr);
                end
                if (bus.dump_valid && bus.dump_ready) begin
                    stalled = 1'b0;
                    if (beat_q.size() == 0) begin
                        fail("beat_extra");
                    end else begin
                        exp_b = beat_q.pop_front();
                        check("beat_addr", bus.dump_addr, exp_b.addr);
                        check("beat_data", bus.dump_data, exp_b.data);
                        if (exp_b.addr == 0) first_cyc = cyc;
                        if (exp_b.addr == DEPTH - 1) begin
                            last_cyc  = cyc;
                            last_xfer = 1'b1;
                        end
                    end
                end else if (bus.dump_valid) begin
                    stalled   = 1'b1;
                    held.addr = bus.dump_addr;
                    held.data = bus.dump_data;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cpu_op(input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d, input logic chk, input logic [31:0] exp);
        @(posedge clk);
        #1;
        bus.we = w; bus.be = b; bus.address = a; bus.wd = d; rd_tag = chk;
        if (chk) rd_exp_q.push_back(exp);
        if (w && a < DEPTH) begin
            for (int i = 0; i < 4; i++) if (b[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
        end
        @(posedge clk);
        #1;
        bus.we = 1'b0; bus.be = '0; bus.address = '0; bus.wd = '0; rd_tag = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"},    bus.rd, 0);
        check({tag, "_oob"},   bus.oob_err, 0);
        check({tag, "_busy"},  bus.dump_busy, 0);
        check({tag, "_valid"}, bus.dump_valid, 0);
        check({tag, "_done"},  bus.dump_done, 0);
        check({tag, "_data"},  bus.dump_data, 0);
        check({tag, "_addr"},  bus.dump_addr, 0);
    endtask

    task automatic apply_reset(input int n, input string tag);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check_reset_outputs(tag);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.dump_start = 1'b1;
        @(posedge clk);
        #1 bus.dump_start = 1'b0;
    endtask

    task automatic push_dump(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.addr = i;
            b.data = mem_m[i];
            beat_q.push_back(b);
        end
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.dump_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail(name);
    endtask

    initial begin
        beat_t b;
        bit    found;
        bus.we = 1'b0; bus.be = '0; bus.address = '0; bus.wd = '0; bus.dump_start = 1'b0;

        apply_reset(2, "rst0");

        for (int i = 0; i < DEPTH; i++) cpu_op(1'b1, 4'hF, i, i * 3, 1'b0, 0);

        // T1: byte-enable merge and read-first behaviour
        cpu_op(1'b1, 4'hF,    5, 32'hDEADBEEF, 1'b0, 0);
        cpu_op(1'b1, 4'b0010, 5, 32'h0000AA00, 1'b0, 0);
        cpu_op(1'b0, 4'h0,    5, 0,            1'b1, 32'hDEADAAEF);
        cpu_op(1'b1, 4'hF,    6, 32'h11111111, 1'b0, 0);
        cpu_op(1'b1, 4'hF,    6, 32'h22222222, 1'b1, 32'h11111111);
        cpu_op(1'b0, 4'h0,    6, 0,            1'b1, 32'h22222222);
        cpu_op(1'b1, 4'hF,    5, 15,           1'b0, 0);
        cpu_op(1'b1, 4'hF,    6, 18,           1'b0, 0);
        check("oob_inrange", bus.oob_err, 0);

        // T2: out-of-range accesses
        cpu_op(1'b1, 4'hF, 16, 32'h12345678, 1'b0, 0);
        check("oob_write", bus.oob_err, 1);
        cpu_op(1'b0, 4'h0, 0,  0, 1'b1, 0);
        cpu_op(1'b0, 4'h0, 7,  0, 1'b1, 21);
        cpu_op(1'b0, 4'h0, 20, 0, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1 check("oob_sticky", bus.oob_err, 1);
        apply_reset(1, "rst_oob");
        @(posedge clk);
        #1 check("oob_cleared", bus.oob_err, 0);
        cpu_op(1'b0, 4'h0, 9, 0, 1'b1, 27);

        // T3: full-throughput dump
        ready_mode = 1;
        push_dump(DEPTH);
        pulse_start();
        check("t3_busy", bus.dump_busy, 1);
        check("t3_valid_e0", bus.dump_valid, 0);
        @(posedge clk);
        #1 check("t3_valid_e1", bus.dump_valid, 0);
        @(posedge clk);
        #1 check("t3_valid_e2", bus.dump_valid, 1);
        check("t3_first_addr", bus.dump_addr, 0);
        wait_done("t3_done_timeout");
        check("t3_throughput", 64'(last_cyc - first_cyc), 15);

        // T4: random backpressure, restart attempt mid-dump must be ignored
        ready_mode = 2;
        push_dump(DEPTH);
        pulse_start();
        repeat (4) @(posedge clk);
        pulse_start();
        wait_done("t4_done_timeout");
        repeat (4) @(posedge clk);
        #1 check("t4_idle_valid", bus.dump_valid, 0);
        check("t4_queue_empty", 64'(beat_q.size()), 0);

        // T5: CPU writes while the dump runs
        ready_mode = 1;
        for (int i = 0; i < DEPTH; i++) begin
            b.addr = i;
            b.data = (i == DEPTH - 1) ? 32'hFFFFFFFF : mem_m[i];
            beat_q.push_back(b);
        end
        pulse_start();
        cpu_op(1'b1, 4'hF, 15, 32'hFFFFFFFF, 1'b0, 0);
        cpu_op(1'b1, 4'hF, 0,  32'hABCD0000, 1'b0, 0);
        wait_done("t5_done_timeout");

        // T6: reset in the middle of a dump, then a clean restart
        push_dump(7);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.dump_valid && bus.dump_ready && bus.dump_addr == 6) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail("t6_beat6_timeout");
        ready_mode = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("t6_abort");
        reset = 1'b0;
        check("t6_queue_empty", 64'(beat_q.size()), 0);
        repeat (3) @(posedge clk);
        #1 check("t6_no_done", bus.dump_done, 0);
        ready_mode = 1;
        push_dump(DEPTH);
        pulse_start();
        wait_done("t6_done_timeout");

        repeat (3) @(posedge clk);
        #1;
        check("end_beats_left", 64'(beat_q.size()), 0);
        check("end_reads_left", 64'(rd_exp_q.size()), 0);
        check("done_count", 64'(done_cnt), 4);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
